// File: rtl/radix4_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides.
// Optional BOOTH_EARLY_TERM_EN: leave RUN once the remaining multiplier digits are all zero.
module radix4_booth_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N  = WIDTH/2 + 1;
  localparam int AW = 2*WIDTH + 2;
  localparam int BW = WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   pp;
  logic            last_digit;
  logic            sa, sb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath: operand latch in IDLE, one digit per cycle in RUN.
  always_comb begin
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplr_d     = mplr_q;
    cnt_d      = cnt_q;
    pp         = '0;
    last_digit = 1'b0;
    sa         = tc & multiplicand[WIDTH-1];
    sb         = tc & multiplier[WIDTH-1];
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = {{(WIDTH+2){sa}}, multiplicand};
          mplr_d  = {{2{sb}}, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        case (mplr_q[2:0])
          3'b001, 3'b010: pp = mcand_q;
          3'b011:         pp = mcand_q << 1;
          3'b100:         pp = '0 - (mcand_q << 1);
          3'b101, 3'b110: pp = '0 - mcand_q;
          default:        pp = '0;
        endcase
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        // Arithmetic shift keeps the sign fill so the all-1 test below stays valid.
        mplr_d  = {{2{mplr_q[BW-1]}}, mplr_q[BW-1:2]};
        cnt_d   = cnt_q + 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
        last_digit = (cnt_q == LAST) || (~|mplr_d) || (&mplr_d);
`else
        last_digit = (cnt_q == LAST);
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_RUN;
      S_RUN:   if (last_digit) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    result    = acc_q[2*WIDTH-1:0];
  end

endmodule

// File: tb/tb_radix4_booth_seq.sv
// Directed bench for radix4_booth_seq (WIDTH=8): products, latency, backpressure, reset.
module tb_radix4_booth_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, tc, out_valid, out_ready, busy;
  logic [7:0]  multiplicand, multiplier;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  radix4_booth_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .tc(tc),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept one pair, measure latency, optionally stall the output, then drain.
  task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic t, input logic [15:0] exp, input int exp_lat, input int stall);
    int lat;
    int n;
    logic [15:0] held;
    @(negedge clk);
    multiplicand = a; multiplier = b; tc = t; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; multiplicand = 8'hA5; multiplier = 8'h5A; tc = ~t;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    else chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, {16'd0, result}, {16'd0, exp});
    held = result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {15'd0, result, in_ready}, {15'd0, held, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] ra, rb;
    logic rt;
    int ia, ib;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tc = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    chk("rst_state", {13'd0, in_ready, out_valid, busy, result}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk); rst = 1'b0;

    mul("s55x55", 8'h55, 8'h55, 1'b1, 16'h1C39, 5, 0);
    mul("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 5, 0);
    mul("sFFx7F", 8'hFF, 8'h7F, 1'b1, 16'hFF81, 5, 0);
    mul("s80x7F", 8'h80, 8'h7F, 1'b1, 16'hC080, 5, 0);
    mul("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 5, 0);
    mul("u80x02", 8'h80, 8'h02, 1'b0, 16'h0100, 5, 0);
    mul("uFFx01", 8'hFF, 8'h01, 1'b0, 16'h00FF, 5, 0);

    // Backpressure with a held in_valid that must wait for the output handshake.
    mul("bp_first", 8'h12, 8'h34, 1'b0, 16'h03A8, 5, 0);
    @(negedge clk);
    multiplicand = 8'h07; multiplier = 8'h09; tc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    multiplicand = 8'h0B; multiplier = 8'h0D; tc = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_res", {16'd0, result}, 32'h0000003F);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {14'd0, result, in_ready, busy}, {14'd0, 16'h003F, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {30'd0, in_ready, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_held_res", {16'd0, result}, 32'h0000008F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset on the 3rd RUN cycle.
    @(negedge clk);
    multiplicand = 8'h55; multiplier = 8'h33; tc = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst", {13'd0, in_ready, out_valid, busy, result}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) n++; end
    chk("no_pulse", n, 0);
    mul("post_rst", 8'h03, 8'h04, 1'b1, 16'h000C, 5, 0);

`ifdef BOOTH_EARLY_TERM_EN
    mul("et_01", 8'h37, 8'h01, 1'b1, 16'h0037, 1, 0);
    mul("et_00", 8'h37, 8'h00, 1'b1, 16'h0000, 1, 0);
    mul("et_FF", 8'h05, 8'hFF, 1'b1, 16'hFFFB, 1, 0);
    mul("et_55", 8'h55, 8'h55, 1'b1, 16'h1C39, -1, 0);
`endif

    // Random pairs against an integer model, random output stall.
    for (int k = 0; k < 300; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rt = 1'($urandom);
      ia = rt ? int'($signed(ra)) : int'(ra);
      ib = rt ? int'($signed(rb)) : int'(rb);
`ifdef BOOTH_EARLY_TERM_EN
      mul("rnd", ra, rb, rt, 16'(ia * ib), -1, int'($urandom_range(0, 3)));
`else
      mul("rnd", ra, rb, rt, 16'(ia * ib), 5, int'($urandom_range(0, 3)));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
